// File: rtl/rr_pkg.sv
// Shared types for the round-robin dispatcher/arbiter pair: port selection
// encoding and a helper that names the opposite port.
package rr_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  function automatic port_sel_e other_port(input port_sel_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_sync_fifo.sv
// Single-clock FIFO with registered head; no push-to-pop bypass, so a pushed
// entry is first visible in the cycle after the push.
module rr_sync_fifo
  import rr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Extra pointer MSB differs only when the write side has lapped the read side.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin splitter: one input stream distributed beat-by-beat onto two
// buffered output streams, redirecting to the other side when one is full.
module rr_dispatcher
  import rr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  A_valid_o,
  input  logic                  A_ready_i,
  output logic [DATA_WIDTH-1:0] A_data_o,
  output logic                  B_valid_o,
  input  logic                  B_ready_i,
  output logic [DATA_WIDTH-1:0] B_data_o,
  output logic [CNT_WIDTH-1:0]  A_cnt_o,
  output logic [CNT_WIDTH-1:0]  B_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  port_sel_e rr_ptr;
  port_sel_e target;
  logic      a_full, b_full, a_empty, b_empty;
  logic      accept, push_a, push_b;

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; ready depends only on registered FIFO state, never on any valid input.
  assign ready_o = !(a_full && b_full);
  assign accept  = valid_i && ready_o;

  always_comb begin
    target = rr_ptr;
    if (rr_ptr == PORT_A) begin
      target = a_full ? PORT_B : PORT_A;
    end else begin
      target = b_full ? PORT_A : PORT_B;
    end
  end

  assign push_a = accept && (target == PORT_A);
  assign push_b = accept && (target == PORT_B);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr  <= PORT_A;
      A_cnt_o <= '0;
      B_cnt_o <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= other_port(target);
      end
      if (push_a) begin
        A_cnt_o <= A_cnt_o + CNT_ONE;
      end
      if (push_b) begin
        B_cnt_o <= B_cnt_o + CNT_ONE;
      end
    end
  end

  rr_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk   (aclk),
    .rst   (areset),
    .push  (push_a),
    .pop   (A_valid_o && A_ready_i),
    .din   (data_i),
    .full  (a_full),
    .empty (a_empty),
    .head  (A_data_o)
  );

  rr_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk   (aclk),
    .rst   (areset),
    .push  (push_b),
    .pop   (B_valid_o && B_ready_i),
    .din   (data_i),
    .full  (b_full),
    .empty (b_empty),
    .head  (B_data_o)
  );

  assign A_valid_o = !a_empty;
  assign B_valid_o = !b_empty;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher: a per-port expected queue models FIFO
// contents, round-robin pointer and counters; every cycle is checked at negedge.
module tb_rr_dispatcher;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          A_valid_o, A_ready_i;
  logic [DW-1:0] A_data_o;
  logic          B_valid_o, B_ready_i;
  logic [DW-1:0] B_data_o;
  logic [CW-1:0] A_cnt_o, B_cnt_o;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic [CW-1:0] m_cnt_a, m_cnt_b;
  bit            m_rr;   // 0 = port A, 1 = port B
  int            tests  = 0;
  int            failed = 0;

  rr_dispatcher #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .A_valid_o (A_valid_o),
    .A_ready_i (A_ready_i),
    .A_data_o  (A_data_o),
    .B_valid_o (B_valid_o),
    .B_ready_i (B_ready_i),
    .B_data_o  (B_data_o),
    .A_cnt_o   (A_cnt_o),
    .B_cnt_o   (B_cnt_o)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model at negedge, advance the
  // model with the pops/pushes of the coming edge, then return #1 after it.
  task automatic step(output bit acc);
    bit a_full, b_full, m_ready, tgt;
    @(negedge aclk);
    acc = 1'b0;
    if (areset) begin
      exp_a.delete();
      exp_b.delete();
      m_rr    = 1'b0;
      m_cnt_a = '0;
      m_cnt_b = '0;
    end else begin
      a_full  = (exp_a.size() == DEPTH);
      b_full  = (exp_b.size() == DEPTH);
      m_ready = !(a_full && b_full);
      chk("ready_o", ready_o, m_ready);
      chk("A_valid", A_valid_o, exp_a.size() != 0);
      chk("B_valid", B_valid_o, exp_b.size() != 0);
      chk("A_cnt", A_cnt_o, m_cnt_a);
      chk("B_cnt", B_cnt_o, m_cnt_b);
      if (exp_a.size() != 0 && A_ready_i) chk("A_data", A_data_o, exp_a.pop_front());
      if (exp_b.size() != 0 && B_ready_i) chk("B_data", B_data_o, exp_b.pop_front());
      if (valid_i && m_ready) begin
        acc = 1'b1;
        tgt = (m_rr == 1'b0) ? a_full : !b_full;
        if (tgt == 1'b0) begin
          exp_a.push_back(data_i);
          m_cnt_a++;
        end else begin
          exp_b.push_back(data_i);
          m_cnt_b++;
        end
        m_rr = !tgt;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    bit acc;
    areset  = 1'b1;
    valid_i = 1'b0;
    step(acc);
    areset  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, ready_o, 1'b1);
    chk({tag, "_A_valid"}, A_valid_o, 1'b0);
    chk({tag, "_B_valid"}, B_valid_o, 1'b0);
    chk({tag, "_A_data"}, A_data_o, 16'h0);
    chk({tag, "_B_data"}, B_data_o, 16'h0);
    chk({tag, "_A_cnt"}, A_cnt_o, 16'h0);
    chk({tag, "_B_cnt"}, B_cnt_o, 16'h0);
  endtask

  initial begin
    bit acc;
    int n;
    m_rr    = 1'b0;
    m_cnt_a = '0;
    m_cnt_b = '0;

    // 1: reset held 3 cycles with valid_i high; nothing may be accepted
    areset    = 1'b1;
    valid_i   = 1'b1;
    data_i    = 16'hdead;
    A_ready_i = 1'b0;
    B_ready_i = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    areset  = 1'b0;
    valid_i = 1'b0;
    check_idle("t1");
    step(acc);

    // 2: back-to-back beats alternate A/B with both consumers ready
    A_ready_i = 1'b1;
    B_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      data_i  = DW'(i);
      step(acc);
      chk("t2_accept", acc, 1'b1);
    end
    valid_i = 1'b0;
    repeat (2) step(acc);
    chk("t2_A_cnt", A_cnt_o, 16'd4);
    chk("t2_B_cnt", B_cnt_o, 16'd4);

    // 3: B stalled fills up; later beats are redirected to A
    do_reset();
    A_ready_i = 1'b1;
    B_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      valid_i = 1'b1;
      data_i  = DW'(i);
      step(acc);
      chk("t3_accept", acc, 1'b1);
    end
    valid_i = 1'b0;
    repeat (2) step(acc);
    chk("t3_A_cnt", A_cnt_o, 16'd8);
    chk("t3_B_cnt", B_cnt_o, 16'd4);
    chk("t3_B_full_size", exp_b.size(), 4);
    B_ready_i = 1'b1;
    repeat (6) step(acc);

    // 4: both stalled until full, then drain
    do_reset();
    A_ready_i = 1'b0;
    B_ready_i = 1'b0;
    valid_i   = 1'b1;
    n         = 0;
    data_i    = '0;
    for (int i = 0; i < 12; i++) begin
      step(acc);
      if (acc) begin
        n++;
        data_i = DW'(n);
      end
    end
    chk("t4_accepted", n, 8);
    chk("t4_ready_low", ready_o, 1'b0);
    valid_i   = 1'b0;
    A_ready_i = 1'b1;
    B_ready_i = 1'b1;
    step(acc);
    chk("t4_ready_after_pop", ready_o, 1'b1);
    repeat (5) step(acc);

    // 5: mid-operation reset discards buffered beats and restarts at A
    do_reset();
    A_ready_i = 1'b0;
    B_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = DW'(i);
      step(acc);
    end
    chk("t5_A_cnt_pre", A_cnt_o, 16'd2);
    chk("t5_B_cnt_pre", B_cnt_o, 16'd1);
    do_reset();
    check_idle("t5");
    A_ready_i = 1'b1;
    B_ready_i = 1'b1;
    valid_i   = 1'b1;
    data_i    = 16'h0055;
    step(acc);
    valid_i = 1'b0;
    chk("t5_first_to_A", A_valid_o, 1'b1);
    chk("t5_not_B", B_valid_o, 1'b0);
    step(acc);

    // 6: gaps in valid_i leave the round-robin pointer where it was
    do_reset();
    A_ready_i = 1'b1;
    B_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      valid_i = (i % 2 == 0);
      data_i  = 16'h0010 + DW'(i / 2);
      step(acc);
    end
    valid_i = 1'b0;
    repeat (2) step(acc);
    chk("t6_A_cnt", A_cnt_o, 16'd2);
    chk("t6_B_cnt", B_cnt_o, 16'd1);

    // random tail: mixed stalls and gaps against the model
    for (int i = 0; i < 200; i++) begin
      valid_i   = ($urandom_range(0, 3) != 0);
      data_i    = DW'($urandom_range(0, 16'hffff));
      A_ready_i = ($urandom_range(0, 2) != 0);
      B_ready_i = ($urandom_range(0, 3) == 0);
      step(acc);
    end
    valid_i   = 1'b0;
    A_ready_i = 1'b1;
    B_ready_i = 1'b1;
    repeat (10) step(acc);
    chk("end_A_empty", exp_a.size(), 0);
    chk("end_B_empty", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
